// File: rtl/maze_census_if.sv
// Tile RAM read port bundle for maze_census.
// The census engine drives the address and strobe. The RAM side returns the
// tile code a fixed number of cycles later.
//   rd_en    master->slave  read strobe, high while addresses are issued
//   rd_addr  master->slave  tile address
//   rd_data  slave->master  tile code
interface maze_census_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/maze_census.sv
// maze_census: sweeps the tile RAM, counts food and power-pellet tiles, and
// publishes registered totals plus game-over / level-clear status.
//
// Ports:
//   clk, reset (async, active low)
//   start        sweep request, only honoured in IDLE
//   tile         tile RAM read port (master side)
//   busy         high whenever not IDLE
//   done         one-cycle pulse when new totals appear
//   food_count   food tiles in last completed sweep
//   power_count  power tiles in last completed sweep
//   total_left   food_count + power_count
//   result_valid a sweep has completed since reset
//   game_over    result_valid and total_left == 0
//   level_clear  one-cycle pulse on game_over rising
//
// state  | meaning
// IDLE   | waiting for start (skipped when AUTO=1)
// SCAN   | issuing addresses 0..NUM_TILES-1, one per cycle
// DRAIN  | RD_LAT cycles collecting in-flight read data
// UPDATE | publish accumulators to the output registers
module maze_census #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int NUM_TILES  = 768,
  parameter int RD_LAT     = 1,
  parameter int FOOD_CODE  = 2,
  parameter int POWER_CODE = 3,
  parameter int CNT_W      = 10,
  parameter int AUTO       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  maze_census_if.master     tile,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  food_count,
  output logic [CNT_W-1:0]  power_count,
  output logic [CNT_W:0]    total_left,
  output logic              result_valid,
  output logic              game_over,
  output logic              level_clear
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_UPDATE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TILES - 1);
  localparam logic [1:0]        DRAIN_INIT = 2'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         drain_q;
  logic [RD_LAT-1:0]  vld_q;
  logic [CNT_W-1:0]   food_acc, power_acc;
  logic               rd_en_i;
  logic               scan_entry;
  logic               drain_load;
  logic               publish;
  logic               sample_ok;
  logic               new_go;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (AUTO != 0 || start) state_d = S_SCAN;
      S_SCAN:   if (addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == 2'd0) state_d = S_UPDATE;
      S_UPDATE: state_d = (AUTO != 0) ? S_SCAN : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs and strobes
  always_comb begin
    rd_en_i    = (state_q == S_SCAN);
    busy       = (state_q != S_IDLE);
    scan_entry = (state_d == S_SCAN) && (state_q != S_SCAN);
    drain_load = (state_q == S_SCAN) && (state_d == S_DRAIN);
    publish    = (state_q == S_UPDATE);
  end

  assign tile.rd_en   = rd_en_i;
  assign tile.rd_addr = addr_q;

  // address counter holds the last address through DRAIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      addr_q <= '0;
    else if (scan_entry)                             addr_q <= '0;
    else if (state_q == S_SCAN && addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
  end

  // drain timer: down-counter, DRAIN exits on terminal count zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   drain_q <= 2'd0;
    else if (drain_load)                          drain_q <= DRAIN_INIT;
    else if (state_q == S_DRAIN && drain_q != 2'd0) drain_q <= drain_q - 2'd1;
  end

  // valid pipeline mirrors the RAM latency so each returned word is qualified
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= (vld_q << 1) | RD_LAT'(rd_en_i);
  end

  assign sample_ok = vld_q[RD_LAT-1];

  // saturating accumulators; the pipeline is empty whenever they are cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      food_acc  <= '0;
      power_acc <= '0;
    end else if (scan_entry) begin
      food_acc  <= '0;
      power_acc <= '0;
    end else if (sample_ok) begin
      if (tile.rd_data == DATA_W'(FOOD_CODE) && food_acc != CNT_MAX)
        food_acc <= food_acc + CNT_W'(1);
      else if (tile.rd_data == DATA_W'(POWER_CODE) && power_acc != CNT_MAX)
        power_acc <= power_acc + CNT_W'(1);
    end
  end

  assign new_go = (food_acc == '0) && (power_acc == '0);

  // published results change only on the UPDATE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      food_count   <= '0;
      power_count  <= '0;
      total_left   <= '0;
      result_valid <= 1'b0;
      game_over    <= 1'b0;
      level_clear  <= 1'b0;
      done         <= 1'b0;
    end else if (publish) begin
      food_count   <= food_acc;
      power_count  <= power_acc;
      total_left   <= {1'b0, food_acc} + {1'b0, power_acc};
      result_valid <= 1'b1;
      game_over    <= new_go;
      level_clear  <= new_go && !game_over;
      done         <= 1'b1;
    end else begin
      level_clear  <= 1'b0;
      done         <= 1'b0;
    end
  end

endmodule
